// File: rtl/ram_arbiter_2p.sv
// Two-requester round-robin arbiter in front of a single-port RAM with a two-cycle read latency.
// Drives the RAM ports and routes each returned read word back to the requester that issued it.
module ram_arbiter_2p #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 7
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req0,
   input  logic                  we0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0] wdata0,
   output logic                  gnt0,
   output logic                  rvalid0,
   input  logic                  req1,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  gnt1,
   output logic                  rvalid1,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_d,
   input  logic [DATA_WIDTH-1:0] ram_q
);

   logic                  prio;
   logic                  s1_valid, s1_id;
   logic                  s2_valid, s2_id;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] d_q;

   logic                  accept;
   logic                  win_id;
   logic                  win_we;
   logic [ADDR_WIDTH-1:0] win_addr;
   logic [DATA_WIDTH-1:0] win_wdata;

   // prio selects the winner only when both requesters contend
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (rst_n) begin
         if (req0 && (!req1 || !prio)) gnt0 = 1'b1;
         else if (req1)                gnt1 = 1'b1;
      end
   end

   always_comb begin
      accept    = gnt0 | gnt1;
      win_id    = gnt1;
      win_we    = gnt1 ? we1    : we0;
      win_addr  = gnt1 ? addr1  : addr0;
      win_wdata = gnt1 ? wdata1 : wdata0;
   end

   // Address and data hold their last granted values while idle
   always_comb begin
      ram_we   = accept & win_we;
      ram_addr = accept ? win_addr  : addr_q;
      ram_d    = accept ? win_wdata : d_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prio     <= 1'b0;
         addr_q   <= '0;
         d_q      <= '0;
         s1_valid <= 1'b0;
         s1_id    <= 1'b0;
         s2_valid <= 1'b0;
         s2_id    <= 1'b0;
      end else begin
         if (accept) begin
            prio   <= gnt0;
            addr_q <= win_addr;
            d_q    <= win_wdata;
         end
         s1_valid <= accept & ~win_we;
         s1_id    <= win_id;
         s2_valid <= s1_valid;
         s2_id    <= s1_id;
      end
   end

   assign rvalid0 = s2_valid & ~s2_id;
   assign rvalid1 = s2_valid &  s2_id;
   assign rdata   = ram_q;

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// Directed bench for ram_arbiter_2p with a behavioural two-cycle RAM and a read-response scoreboard.
// Stimulus pushes expected read responses; a negedge monitor pops and checks them.
module tb_ram_arbiter_2p;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0, we0, req1, we1;
   logic [6:0]  addr0, addr1;
   logic [31:0] wdata0, wdata1;
   logic        gnt0, gnt1, rvalid0, rvalid1;
   logic [31:0] rdata;
   logic        ram_we;
   logic [6:0]  ram_addr;
   logic [31:0] ram_d;
   logic [31:0] ram_q;

   always #5 clk = ~clk;

   ram_arbiter_2p #(.DATA_WIDTH(32), .ADDR_WIDTH(7)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1),
      .rdata(rdata), .ram_we(ram_we), .ram_addr(ram_addr), .ram_d(ram_d), .ram_q(ram_q)
   );

   // RAM model: address registered at the access edge, output registered one edge later
   logic [31:0] mem [128];
   logic [31:0] q1;
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_d;
      q1    <= mem[ram_addr];
      ram_q <= q1;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic        id;
      logic [31:0] data;
      int          due;
   } exp_t;
   exp_t sb[$];

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input logic id, input logic [31:0] data);
      exp_t e;
      e.id   = id;
      e.data = data;
      e.due  = cyc + 2;
      sb.push_back(e);
   endtask

   task automatic set(input logic r0, input logic w0, input logic [6:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic [6:0] a1, input logic [31:0] d1);
      req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
      req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
   endtask

   // Check the current cycle at negedge, then advance to just past the next rising edge
   task automatic step(input logic eg0, input logic eg1, input logic ewe, input logic [6:0] ea,
                       input logic rvz);
      @(negedge clk);
      chk("gnt0", gnt0, eg0);
      chk("gnt1", gnt1, eg1);
      chk("ram_we", ram_we, ewe);
      chk("ram_addr", ram_addr, ea);
      if (rvz) begin
         chk("rvalid0_idle", rvalid0, 1'b0);
         chk("rvalid1_idle", rvalid1, 1'b0);
      end
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (gnt0 && gnt1) begin
         tests++;
         fails++;
         $display("FAIL gnt_onehot: got gnt0=1 gnt1=1, required at most one (cycle %0d)", cyc);
      end
      if (rvalid0 || rvalid1) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_rvalid: got rvalid0=%0b rvalid1=%0b, required none (cycle %0d)",
                     rvalid0, rvalid1, cyc);
         end else begin
            e = sb.pop_front();
            chk("rsp_onehot", {31'd0, rvalid0 & rvalid1}, 32'd0);
            chk("rsp_id", {31'd0, rvalid1}, {31'd0, e.id});
            chk("rsp_data", rdata, e.data);
            chk("rsp_cycle", cyc, e.due);
         end
      end
   end

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 32'h0;
      mem[7'h10] = 32'h1111_1111;
      mem[7'h20] = 32'h2222_2222;
      rst_n = 1'b0;
      set(1, 0, 7'h10, 0, 1, 0, 7'h20, 0);
      @(posedge clk);
      #1;

      // reset held with both requesting
      for (int i = 0; i < 3; i++) step(0, 0, 0, 7'h00, 1);
      chk("ram_d_reset", ram_d, 32'h0);

      // first grant after reset goes to requester 0
      rst_n = 1'b1;
      set(1, 1, 7'h05, 32'hDEAD_BEEF, 1, 0, 7'h10, 0);
      step(1, 0, 1, 7'h05, 0);
      set(1, 0, 7'h05, 0, 1, 0, 7'h10, 0);
      push(1, 32'h1111_1111);
      step(0, 1, 0, 7'h10, 0);
      set(1, 0, 7'h05, 0, 0, 0, 0, 0);
      push(0, 32'hDEAD_BEEF);
      step(1, 0, 0, 7'h05, 0);

      // write then read of the same address in the next cycle
      set(1, 1, 7'h06, 32'hCAFE_F00D, 0, 0, 0, 0);
      step(1, 0, 1, 7'h06, 0);
      set(1, 0, 7'h06, 0, 0, 0, 0, 0);
      push(0, 32'hCAFE_F00D);
      step(1, 0, 0, 7'h06, 0);

      // requester 1 writes the top address; prio returns to 0
      set(0, 0, 0, 0, 1, 1, 7'h7F, 32'hA5A5_A5A5);
      step(0, 1, 1, 7'h7F, 0);

      // contention: both read continuously, grants alternate starting with 0
      set(1, 0, 7'h10, 0, 1, 0, 7'h20, 0);
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) begin
            push(0, 32'h1111_1111);
            step(1, 0, 0, 7'h10, 0);
         end else begin
            push(1, 32'h2222_2222);
            step(0, 1, 0, 7'h20, 0);
         end
      end

      // boundary address read back, address 0 untouched
      set(1, 0, 7'h00, 0, 1, 0, 7'h7F, 0);
      push(0, 32'h0);
      step(1, 0, 0, 7'h00, 0);
      set(0, 0, 0, 0, 1, 0, 7'h7F, 0);
      push(1, 32'hA5A5_A5A5);
      step(0, 1, 0, 7'h7F, 0);

      // leave prio pointing at 1, idle, then confirm it was held
      set(1, 0, 7'h10, 0, 0, 0, 0, 0);
      push(0, 32'h1111_1111);
      step(1, 0, 0, 7'h10, 0);
      set(0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 7'h10, 0);
      step(0, 0, 0, 7'h10, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 7'h10, 1);
      set(1, 0, 7'h10, 0, 1, 0, 7'h20, 0);
      push(1, 32'h2222_2222);
      step(0, 1, 0, 7'h20, 0);
      set(0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 7'h20, 0);
      step(0, 0, 0, 7'h20, 0);

      // reset while a read is in flight: the read is dropped
      set(1, 0, 7'h05, 0, 0, 0, 0, 0);
      step(1, 0, 0, 7'h05, 0);
      set(0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      step(0, 0, 0, 7'h05, 0);
      rst_n = 1'b1;
      step(0, 0, 0, 7'h00, 1);
      step(0, 0, 0, 7'h00, 1);

      // prio is back at 0 after reset
      set(1, 0, 7'h05, 0, 1, 0, 7'h20, 0);
      push(0, 32'hDEAD_BEEF);
      step(1, 0, 0, 7'h05, 0);
      set(0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 7'h05, 0);

      chk("sb_drained", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ram_arbiter_2p.md
Name: ram_arbiter_2p

Overview:
- Two-requester round-robin arbiter for the single-port, registered-read 128x32 RAM.
- Issues at most one RAM access per cycle and drives the RAM write-enable, address and data ports.
- Tracks in-flight reads through the RAM's two-cycle read latency and returns each read word to the requester that issued it.
- Sits between two client engines (e.g. DMA and CPU port) and one RAM instance.

Parameters:
DATA_WIDTH, 32, bits per RAM word
ADDR_WIDTH, 7, RAM address bits (2**ADDR_WIDTH words)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
req0  input  1  requester 0 access request
we0  input  1  requester 0 write (1) / read (0)
addr0  input  ADDR_WIDTH  requester 0 address
wdata0  input  DATA_WIDTH  requester 0 write data
gnt0  output  1  requester 0 granted this cycle (combinational)
rvalid0  output  1  read data valid for requester 0
req1, we1, addr1, wdata1, gnt1, rvalid1  same as above for requester 1
rdata  output  DATA_WIDTH  read data, shared by both requesters, qualified by rvalid0/rvalid1
ram_we  output  1  to RAM we
ram_addr  output  ADDR_WIDTH  to RAM address
ram_d  output  DATA_WIDTH  to RAM d
ram_q  input  DATA_WIDTH  from RAM q

Behaviour:
- Handshake: an access is accepted at a rising edge where reqX=1 and gntX=1. Requesters hold req, we, addr and wdata stable until accepted. gnt is a combinational function of req and the priority pointer; gnt0 and gnt1 are never both 1.
- Arbitration:
  - Only one requester asserting req: it is granted.
  - Both asserting: the requester selected by the 1-bit priority pointer prio wins.
  - After any accepted access, prio points to the other requester.
  - No request: prio is unchanged.
- RAM drive:
  - With a grant: ram_addr, ram_d and ram_we = the winner's addr, wdata and we.
  - No grant: ram_we=0, ram_addr and ram_d hold their last values (no RAM write occurs).
- Read tracking: 2-stage shift pipeline of {valid, id}.
  - Stage 1 loads {accepted & ~we, winner id} each edge.
  - Stage 2 loads stage 1.
  - rvalidX = stage2.valid & (stage2.id == X).
  - rdata = ram_q, passed through combinationally.
- Latency: read accepted at the end of cycle C -> rvalidX=1 with rdata=mem[addr] during cycle C+2 for exactly one cycle. Back-to-back reads give back-to-back rvalid in request order.
- Writes produce no response. Write accepted in cycle C, read of the same address accepted in C+1 -> returns the new data.
- Throughput: 1 access per cycle. Under continuous requests from both sides, grants alternate 0,1,0,1.
- Reset (rst_n=0 at a rising edge):
  - prio=0 and both pipeline stages cleared.
  - rvalid0=rvalid1=0 from the next cycle; ram_addr=0, ram_d=0.
  - While rst_n=0: gnt0=gnt1=0 and ram_we=0.
  - Reads in flight at reset are dropped and never signalled valid.
- Width rules: addresses pass unmodified, with no wrap logic in the arbiter; address 2**ADDR_WIDTH-1 is a valid access.
- Target size: 150-250 lines RTL.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with req0=req1=1 -> gnt0=gnt1=0, ram_we=0, rvalid0=rvalid1=0; after release, first grant goes to requester 0.
- Single write/read: req0 writes 0xDEADBEEF to 0x05, next cycle req0 reads 0x05 -> rvalid0=1 two cycles after the read handshake with rdata=0xDEADBEEF; rvalid1 stays 0.
- Contention: req0 and req1 both read continuously for 8 cycles (addresses 0x10 and 0x20 preloaded with 0x11111111 and 0x22222222) -> grants alternate 0,1,0,...; rvalid0/rvalid1 alternate starting 2 cycles later with matching data.
- Boundary address: requester 1 writes 0xA5A5A5A5 to 0x7F then reads 0x7F -> rdata=0xA5A5A5A5 on rvalid1; address 0x00 unaffected.
- Reset mid-read: read accepted in cycle C, rst_n=0 in cycle C+1 -> no rvalid in C+2 or later; prio=0 after reset.
- Idle: no requests for 5 cycles -> ram_we=0, no rvalid, prio unchanged from its pre-idle value.
